pipe_ctrl: RTL

Central stall/flush scheduler for the five-stage integer pipeline. It watches hazard sources and drives the hold and flush controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers:

- load-use dependences
- taken branches and jumps
- data-memory wait states
- multi-cycle mul/div operations

A small registered FSM tracks the multi-cycle waits. Hold/flush outputs are decoded from FSM state and live hazard inputs, and a stall-cycle counter is provided for performance measurement.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for a five-stage integer pipeline: arbitrates memory waits,
// multi-cycle mul/div, control-flow redirects and load-use hazards into hold/flush controls.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_rmem_en_i,
    input  logic [4:0]       ex_wreg_addr_i,
    input  logic             ex_jump_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_mdiv_start_i,
    input  logic             ex_mdiv_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             id_ex_hold_o,
    output logic             ex_mem_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_redirect_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        MDIV_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_stall;
    logic mdiv_stall;
    logic redirect;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Hazard classification; each term is already masked by every higher-priority event.
    always_comb begin
        mem_stall  = !mem_ready_i &&
                     ((state_q == MEM_WAIT) || ((state_q == RUN) && mem_req_i));
        mdiv_stall = !mem_stall && !ex_mdiv_done_i &&
                     ((state_q == MDIV_WAIT) || ((state_q == RUN) && ex_mdiv_start_i));
        redirect   = ex_jump_i && !mem_stall && !mdiv_stall;
        rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_wreg_addr_i);
        rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_wreg_addr_i);
        load_use   = ex_rmem_en_i && (ex_wreg_addr_i != 5'd0) && (rs1_hit || rs2_hit) &&
                     !mem_stall && !mdiv_stall && !ex_jump_i;
    end

    // NOTE: state and counter registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d = MEM_WAIT;
                end else if (ex_mdiv_start_i && !ex_mdiv_done_i) begin
                    state_d = MDIV_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = RUN;
                end
            end
            MDIV_WAIT: begin
                if (ex_mdiv_done_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_hold_o      = 1'b0;
        if_id_hold_o   = 1'b0;
        id_ex_hold_o   = 1'b0;
        ex_mem_hold_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        pc_redirect_o  = 1'b0;
        if (rst) begin
            // Bubbles everywhere while the pipeline is held in reset.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mem_stall) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_hold_o  = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mdiv_stall) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (redirect) begin
            pc_redirect_o  = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_flush_o  = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(pc_hold_o);
    end

    assign pc_redirect_addr_o = ex_jump_addr_i;
    assign stall_cnt_o        = cnt_q;

endmodule
